// File: rtl/gpr_bank.sv
// gpr_bank: clocked register bank with a bypassed read port and a sequential multi-operand sum engine
module gpr_bank #(
    parameter int DATA_W = 14,
    parameter int ADDR_W = 12,
    parameter int REG_N  = 16,
    parameter int REG_W  = 4,
    parameter int OPS    = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rd_en,
    input  logic [ADDR_W-1:0]        rd_addr,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     rd_valid,
    input  logic                     sum_start,
    input  logic [ADDR_W-1:0]        sum_addr,
    input  logic [$clog2(OPS+1)-1:0] sum_cnt,
    output logic                     sum_busy,
    output logic                     sum_done,
    output logic [DATA_W-1:0]        sum_data,
    output logic [DATA_W-1:0]        flags_out
);
    localparam int CNT_W = $clog2(OPS+1);
    localparam int ACC_W = DATA_W + 2;

    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   regs_q [REG_N];
    logic [DATA_W-1:0]   regs_d [REG_N];
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic                rd_valid_q, rd_valid_d;
    logic [ADDR_W-1:0]   ops_q, ops_d;
    logic [CNT_W-1:0]    rem_q, rem_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic                busy_q, busy_d;
    logic                sum_done_q, sum_done_d;
    logic [DATA_W-1:0]   sum_data_q, sum_data_d;

    logic [REG_W-1:0]    wr_idx, rd_idx, op_idx;
    logic                wr_hit;
    logic [CNT_W-1:0]    cnt_sat;
    logic [DATA_W-1:0]   rd_val, op_val;

    assign wr_idx  = wr_addr[ADDR_W-1 -: REG_W];
    assign rd_idx  = rd_addr[ADDR_W-1 -: REG_W];
    // operand fields are consumed MSB-first by shifting the latched address word left
    assign op_idx  = ops_q[ADDR_W-1 -: REG_W];
    assign wr_hit  = wr_en && (int'(wr_idx) < REG_N);
    assign cnt_sat = (int'(sum_cnt) > OPS) ? CNT_W'(OPS) : sum_cnt;
    assign rd_val  = (int'(rd_idx) < REG_N) ? regs_q[rd_idx] : '0;
    assign op_val  = (int'(op_idx) < REG_N) ? regs_q[op_idx] : '0;

    // register file update (flags from the sum engine first, so the write port wins) and bypassed read
    always_comb begin
        regs_d = regs_q;
        if (state_q == DONE)
            regs_d[REG_N-1][1:0] = {acc_q[ACC_W-1:DATA_W] != '0, acc_q[DATA_W-1:0] == '0};
        if (wr_hit)
            regs_d[wr_idx] = wr_data;
        rd_valid_d = rd_en;
        rd_data_d  = !rd_en ? rd_data_q : (wr_hit && wr_idx == rd_idx) ? wr_data : rd_val;
    end

    // sum engine: latch operands, accumulate one field per cycle, then publish result
    always_comb begin
        state_d    = state_q;
        ops_d      = ops_q;
        rem_d      = rem_q;
        acc_d      = acc_q;
        busy_d     = busy_q;
        sum_done_d = 1'b0;
        sum_data_d = sum_data_q;
        case (state_q)
            IDLE: if (sum_start) begin
                ops_d   = sum_addr;
                rem_d   = cnt_sat;
                acc_d   = '0;
                busy_d  = 1'b1;
                state_d = (cnt_sat == '0) ? DONE : ACC;
            end
            ACC: begin
                acc_d   = acc_q + ACC_W'(op_val);
                ops_d   = ops_q << REG_W;
                rem_d   = rem_q - CNT_W'(1);
                state_d = (rem_q == CNT_W'(1)) ? DONE : ACC;
            end
            DONE: begin
                sum_data_d = acc_q[DATA_W-1:0];
                sum_done_d = 1'b1;
                busy_d     = 1'b0;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // all state flops, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs_q     <= '{default: '0};
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            state_q    <= IDLE;
            ops_q      <= '0;
            rem_q      <= '0;
            acc_q      <= '0;
            busy_q     <= 1'b0;
            sum_done_q <= 1'b0;
            sum_data_q <= '0;
        end else begin
            regs_q     <= regs_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            state_q    <= state_d;
            ops_q      <= ops_d;
            rem_q      <= rem_d;
            acc_q      <= acc_d;
            busy_q     <= busy_d;
            sum_done_q <= sum_done_d;
            sum_data_q <= sum_data_d;
        end
    end

    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign sum_busy  = busy_q;
    assign sum_done  = sum_done_q;
    assign sum_data  = sum_data_q;
    assign flags_out = regs_q[REG_N-1];

endmodule

// File: doc/gpr_bank.md
# gpr_bank

Parametrised general-purpose register bank for the CPU datapath. It replaces the combinational register array with a clocked bank that has one write port, one registered read port, and a sequential multi-operand sum engine that adds up to OPS register fields packed in one address word. Register REG_N-1 is the flags register, which the sum engine updates automatically. The bank sits between the instruction decoder (addresses) and the ALU/bus (data).

## Interface
Parameters:
- DATA_W, 14, register width.
- ADDR_W, 12, address word width; register indices are packed MSB-first in REG_W-bit fields.
- REG_N, 16, number of registers; index REG_N-1 is the flags register.
- REG_W, 4, register index field width; REG_N <= 2**REG_W.
- OPS, 3, maximum fields per sum; ADDR_W >= OPS*REG_W is required.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- wr_en  in  1  write strobe.
- wr_addr  in  ADDR_W  write index in bits [ADDR_W-1 -: REG_W].
- wr_data  in  DATA_W  write data.
- rd_en  in  1  single-register read request.
- rd_addr  in  ADDR_W  read index in bits [ADDR_W-1 -: REG_W].
- rd_data  out  DATA_W  registered read data.
- rd_valid  out  1  one-cycle pulse when rd_data is updated.
- sum_start  in  1  starts a sum; accepted only when sum_busy=0.
- sum_addr  in  ADDR_W  packed operand indices; field k is [ADDR_W-1-k*REG_W -: REG_W].
- sum_cnt  in  clog2(OPS+1)  number of fields to add (0..OPS); values above OPS saturate to OPS.
- sum_busy  out  1  high from the accept edge until the done edge.
- sum_done  out  1  one-cycle pulse when sum_data is valid.
- sum_data  out  DATA_W  sum result; held until the next done.
- flags_out  out  DATA_W  continuous copy of register REG_N-1.

## Operation
- Reset (async): all registers=0, rd_data=0, rd_valid=0, sum_busy=0, sum_done=0, sum_data=0, FSM=IDLE.
- Write: on a clk edge with wr_en=1, the indexed register takes wr_data. Indices >= REG_N are ignored.
- Read: on a clk edge with rd_en=1, rd_data takes the indexed register and rd_valid=1 for one cycle. A write to the same index in the same cycle is bypassed, so rd_data gets wr_data. Indices >= REG_N read 0.
- Sum FSM has three states: IDLE, ACC, DONE.
  - IDLE: when sum_start=1, latch sum_addr and sum_cnt, clear the accumulator, set k=0 and sum_busy=1. Go to DONE if cnt=0, otherwise go to ACC.
  - ACC: add register[field k] to a (DATA_W+2)-bit accumulator, then k++. After field cnt-1, go to DONE. Operand reads are not bypassed: a write committed on the same edge is not seen, and a write on an earlier edge is seen.
  - DONE: sum_data = acc[DATA_W-1:0], sum_done=1, sum_busy=0. Flags register bit0 = (truncated sum == 0) and bit1 = (acc[DATA_W+1:DATA_W] != 0); other flag bits are preserved. Return to IDLE.
- sum_start while busy: ignored (no queueing).
- Flags conflict: if wr_en targets REG_N-1 on the DONE edge, the write-port value wins.
- Flags register may appear as a sum operand; it contributes its pre-update value.

## Timing
- Read latency: 1 cycle, from the rd_en edge to rd_data/rd_valid.
- Sum latency: cnt+1 cycles, from the accept edge to sum_done. cnt=0 gives done 1 cycle later with sum 0 and the zero flag set.
- Back-to-back sums: sum_start may be asserted in the sum_done cycle, because the FSM is in IDLE on the next edge. Minimum period is cnt+2 cycles.
- Read port and sum engine run concurrently and do not stall each other.
- rst asserted mid-sum: everything clears immediately; no sum_done is emitted.

## Test plan
- Reset, then write R1=0x0005 and read R1 -> rd_data=0x0005, rd_valid pulses once, flags_out=0.
- Same-cycle wr_en/rd_en to R2 with data 0x1ABC -> rd_data=0x1ABC next cycle (bypass).
- R0=1, R1=2, R2=3, sum_addr=0x012, cnt=3 -> sum_busy for 4 cycles, sum_data=6, flags bit0=0, bit1=0.
- R3=R4=R5=0x3FFF, sum_addr=0x345, cnt=3 -> sum_data=0x3FFD, flags bit1=1; cnt=0 -> sum_data=0 and bit0=1 after 1 cycle.
- sum_start during busy -> ignored, only one sum_done. wr_en to R15=0x00F0 on the DONE edge -> flags_out=0x00F0.
- Assert rst while the FSM is in ACC -> sum_busy=0, no sum_done, all registers 0 on the next read.
